display_mode_ctrl: RTL and testbench

- Sequencer for the clock's 8-digit display multiplexer.
- Generates the time/date view-select (sw) for the display mux, plus a per-digit blank mask for edit-mode blinking.
- Debounces three front-panel buttons and runs auto-rotate, manual and edit modes.
- Issues increment pulses to the time/date counters, tagged with the field being edited.

---
 rtl/display_mode_ctrl.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_display_mode_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_mode_ctrl.sv
// display_mode_ctrl -- mode sequencer for the 8-digit clock display.
//
// Picks the time/date view for the display mux, blinks the digits of the
// field being edited, debounces the three front-panel buttons and issues
// increment requests to the time/date counters.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   tick_1hz_i      one-cycle pulse per second
//   btn_mode_i      raw mode button (asynchronous)
//   btn_set_i       raw set button (asynchronous)
//   btn_up_i        raw up button (asynchronous)
//   sw_o            view select: 0 = time, 1 = date
//   blank_o[7:0]    per-digit blank, bit i = led(i+1), 1 = blank
//   edit_field_o    0 none, 1 SEC, 2 MIN, 3 HOUR, 4 DAY, 5 MONTH, 6 YEAR
//   inc_pulse_o     one-cycle increment request for edit_field_o
//   editing_o       high in EDIT
//   auto_on_o       high in AUTO

// Per-button path: 2-FF synchronizer, stability counter, registered
// rising-edge press. Press appears DEB_CYC+3 cycles after a clean edge.
module display_mode_btn #(
    parameter int DEB_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d, level_prev_q, press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronized input disagrees with the
    // accepted level; any agreeing cycle restarts the run.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) level_d = sync2_q;
            else                   cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            cnt_q        <= cnt_d;
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
        end
    end

    assign press_o = press_q;
endmodule

module display_mode_ctrl #(
    parameter int DEB_CYC      = 500000,
    parameter int BLINK_CYC    = 12500000,
    parameter int T_TIME       = 8,
    parameter int T_DATE       = 3,
    parameter int EDIT_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz_i,
    input  logic       btn_mode_i,
    input  logic       btn_set_i,
    input  logic       btn_up_i,
    output logic       sw_o,
    output logic [7:0] blank_o,
    output logic [2:0] edit_field_o,
    output logic       inc_pulse_o,
    output logic       editing_o,
    output logic       auto_on_o
);
    // One second counter serves both the auto-rotate dwell and the edit
    // idle timeout, so it is sized for the largest of the three.
    localparam int SEC_MAX0 = (T_TIME > T_DATE) ? T_TIME : T_DATE;
    localparam int SEC_MAX  = (SEC_MAX0 > EDIT_TIMEOUT) ? SEC_MAX0 : EDIT_TIMEOUT;
    localparam int SW = $clog2(SEC_MAX + 1);
    localparam int BW = $clog2(BLINK_CYC + 1);

    localparam logic [SW-1:0] TIME_LAST  = SW'(T_TIME - 1);
    localparam logic [SW-1:0] DATE_LAST  = SW'(T_DATE - 1);
    localparam logic [SW-1:0] IDLE_LAST  = SW'(EDIT_TIMEOUT - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

    localparam logic [2:0] F_NONE  = 3'd0;
    localparam logic [2:0] F_SEC   = 3'd1;
    localparam logic [2:0] F_MIN   = 3'd2;
    localparam logic [2:0] F_HOUR  = 3'd3;
    localparam logic [2:0] F_DAY   = 3'd4;
    localparam logic [2:0] F_MONTH = 3'd5;
    localparam logic [2:0] F_YEAR  = 3'd6;

    typedef enum logic [1:0] {
        S_AUTO = 2'd0,
        S_MAN  = 2'd1,
        S_EDIT = 2'd2
    } state_e;

    // Button lanes: 0 = set, 1 = mode, 2 = up.
    logic [2:0] btn_raw, press;
    assign btn_raw = {btn_up_i, btn_mode_i, btn_set_i};

    display_mode_btn #(.DEB_CYC(DEB_CYC)) u_btn [2:0] (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_raw),
        .press_o(press)
    );

    // set > mode > up; losers in the same cycle are dropped.
    logic p_set, p_mode, p_up;
    assign p_set  = press[0];
    assign p_mode = press[1] & ~press[0];
    assign p_up   = press[2] & ~press[1] & ~press[0];

    function automatic logic [2:0] next_field(input logic [2:0] f);
        case (f)
            F_HOUR:  return F_MIN;
            F_MIN:   return F_SEC;
            F_SEC:   return F_HOUR;
            F_DAY:   return F_MONTH;
            F_MONTH: return F_YEAR;
            F_YEAR:  return F_DAY;
            default: return f;
        endcase
    endfunction

    function automatic logic [7:0] field_mask(input logic [2:0] f);
        case (f)
            F_HOUR, F_DAY:  return 8'hC0;
            F_MIN, F_MONTH: return 8'h30;
            F_YEAR:         return 8'h0F;
            F_SEC:          return 8'h03;
            default:        return 8'h00;
        endcase
    endfunction

    state_e        state_q, state_d;
    logic          v_q, v_d;
    logic [SW-1:0] sec_q, sec_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic [2:0]    field_q, field_d;
    logic          inc_q, inc_d;
    logic [7:0]    blank_q, blank_d;
    logic          editing_q, auto_q;

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        sec_d   = sec_q;
        blink_d = blink_q;
        phase_d = phase_q;
        field_d = field_q;
        inc_d   = 1'b0;

        case (state_q)
            S_AUTO: begin
                if (p_set) begin
                    state_d = S_EDIT;
                    field_d = v_q ? F_DAY : F_HOUR;
                    sec_d   = '0;
                    blink_d = '0;
                    phase_d = 1'b0;
                end else if (p_mode) begin
                    state_d = S_MAN;
                    sec_d   = '0;
                end else if (tick_1hz_i) begin
                    if (sec_q == (v_q ? DATE_LAST : TIME_LAST)) begin
                        v_d   = ~v_q;
                        sec_d = '0;
                    end else begin
                        sec_d = sec_q + 1'b1;
                    end
                end
            end
            S_MAN: begin
                if (p_set) begin
                    state_d = S_EDIT;
                    field_d = v_q ? F_DAY : F_HOUR;
                    sec_d   = '0;
                    blink_d = '0;
                    phase_d = 1'b0;
                end else if (p_mode) begin
                    v_d = ~v_q;
                end else if (p_up) begin
                    state_d = S_AUTO;
                    sec_d   = '0;
                end
            end
            S_EDIT: begin
                if (blink_q == BLINK_LAST) begin
                    blink_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    blink_d = blink_q + 1'b1;
                end
                if (tick_1hz_i) begin
                    if (sec_q == IDLE_LAST) begin
                        state_d = S_MAN;
                        field_d = F_NONE;
                        sec_d   = '0;
                        blink_d = '0;
                        phase_d = 1'b0;
                    end else begin
                        sec_d = sec_q + 1'b1;
                    end
                end
                // Any press restarts idle and blink so the digits show at once.
                if (p_set | p_mode | p_up) begin
                    sec_d   = '0;
                    blink_d = '0;
                    phase_d = 1'b0;
                    state_d = S_EDIT;
                    field_d = field_q;
                    if (p_set) begin
                        state_d = S_MAN;
                        field_d = F_NONE;
                    end else if (p_mode) begin
                        field_d = next_field(field_q);
                    end else begin
                        inc_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_AUTO;
                sec_d   = '0;
                blink_d = '0;
                phase_d = 1'b0;
                field_d = F_NONE;
            end
        endcase

        blank_d = phase_d ? field_mask(field_d) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_AUTO;
            v_q       <= 1'b0;
            sec_q     <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b0;
            field_q   <= F_NONE;
            inc_q     <= 1'b0;
            blank_q   <= 8'h00;
            editing_q <= 1'b0;
            auto_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            sec_q     <= sec_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            field_q   <= field_d;
            inc_q     <= inc_d;
            blank_q   <= blank_d;
            editing_q <= (state_d == S_EDIT);
            auto_q    <= (state_d == S_AUTO);
        end
    end

    assign sw_o         = v_q;
    assign blank_o      = blank_q;
    assign edit_field_o = field_q;
    assign inc_pulse_o  = inc_q;
    assign editing_o    = editing_q;
    assign auto_on_o    = auto_q;
endmodule

// File: tb/tb_display_mode_ctrl.sv
// Bench for display_mode_ctrl: directed button/tick stimulus, a cycle model
// of the specified behaviour checked every cycle, plus literal spot checks.
module tb_display_mode_ctrl;
    localparam int DEB   = 4;
    localparam int BLINK = 8;
    localparam int TT    = 3;
    localparam int TD    = 2;
    localparam int TOUT  = 5;

    logic       clk;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0, btn_set = 1'b0, btn_up = 1'b0;
    logic       sw, inc_pulse, editing, auto_on;
    logic [7:0] blank;
    logic [2:0] edit_field;

    int n_cmp = 0;
    int n_fail = 0;

    display_mode_ctrl #(
        .DEB_CYC(DEB), .BLINK_CYC(BLINK), .T_TIME(TT), .T_DATE(TD), .EDIT_TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz_i(tick),
        .btn_mode_i(btn_mode), .btn_set_i(btn_set), .btn_up_i(btn_up),
        .sw_o(sw), .blank_o(blank), .edit_field_o(edit_field),
        .inc_pulse_o(inc_pulse), .editing_o(editing), .auto_on_o(auto_on)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // States: 0 AUTO, 1 MAN, 2 EDIT. Blink phase is derived from the number
    // of cycles since EDIT entry / last press rather than tracked.
    int m_state, m_v, m_ticks, m_idle, m_field, m_inc, m_cyc, m_ref;
    logic [2:0] acc, h1, h2, pend0, pend1;
    int run [3];
    int next_f [7]   = '{0, 3, 1, 2, 5, 6, 4};
    int mask_tab [7] = '{'h00, 'h03, 'h30, 'hC0, 'hC0, 'h30, 'h0F};

    task automatic model_reset();
        m_state = 0; m_v = 0; m_ticks = 0; m_idle = 0; m_field = 0;
        m_inc = 0; m_cyc = 0; m_ref = 0;
        acc = '0; h1 = '0; h2 = '0; pend0 = '0; pend1 = '0;
        for (int b = 0; b < 3; b++) run[b] = 0;
    endtask

    task automatic enter_edit();
        m_state = 2;
        m_field = m_v ? 4 : 3;
        m_ref = m_cyc;
        m_idle = 0;
    endtask

    task automatic model_step();
        logic [2:0] act;
        logic [2:0] raw;
        raw = {btn_up, btn_mode, btn_set};
        m_cyc++;
        // A level accepted at edge k is acted on at edge k+2.
        act = pend1;
        pend1 = pend0;
        pend0 = '0;
        // Synchronized value seen now is the raw level from two edges ago.
        for (int b = 0; b < 3; b++) begin
            if (h2[b] != acc[b]) begin
                run[b]++;
                if (run[b] == DEB) begin
                    acc[b] = h2[b];
                    run[b] = 0;
                    pend0[b] = h2[b];
                end
            end else begin
                run[b] = 0;
            end
        end
        h2 = h1;
        h1 = raw;
        m_inc = 0;
        case (m_state)
            0: begin
                if (act[0]) enter_edit();
                else if (act[1]) m_state = 1;
                else if (tick) begin
                    m_ticks++;
                    if (m_ticks == (m_v ? TD : TT)) begin
                        m_v = 1 - m_v;
                        m_ticks = 0;
                    end
                end
            end
            1: begin
                if (act[0]) enter_edit();
                else if (act[1]) m_v = 1 - m_v;
                else if (act[2]) begin
                    m_state = 0;
                    m_ticks = 0;
                end
            end
            default: begin
                if (act[0]) begin
                    m_state = 1;
                    m_field = 0;
                end else if (act[1]) begin
                    m_field = next_f[m_field];
                    m_ref = m_cyc;
                    m_idle = 0;
                end else if (act[2]) begin
                    m_inc = 1;
                    m_ref = m_cyc;
                    m_idle = 0;
                end else if (tick) begin
                    m_idle++;
                    if (m_idle == TOUT) begin
                        m_state = 1;
                        m_field = 0;
                    end
                end
            end
        endcase
    endtask

    function automatic int exp_blank();
        if (m_state == 2 && (((m_cyc - m_ref) / BLINK) % 2) == 1) return mask_tab[m_field];
        return 0;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("sw", 32'(sw), 32'(m_v));
            chk("blank", 32'(blank), 32'(exp_blank()));
            chk("edit_field", 32'(edit_field), 32'(m_field));
            chk("inc_pulse", 32'(inc_pulse), 32'(m_inc));
            chk("editing", 32'(editing), 32'(m_state == 2));
            chk("auto_on", 32'(auto_on), 32'(m_state == 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic val);
        case (b)
            0: btn_set = val;
            1: btn_mode = val;
            default: btn_up = val;
        endcase
    endtask

    // Hold a button until its press has acted (8 edges), then leave it held.
    task automatic push(input int b);
        set_btn(b, 1'b1);
        cyc(8);
    endtask

    task automatic rel(input int b);
        set_btn(b, 1'b0);
        cyc(8);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sw"}, 32'(sw), 32'd0);
        chk({tag, "_blank"}, 32'(blank), 32'd0);
        chk({tag, "_field"}, 32'(edit_field), 32'd0);
        chk({tag, "_inc"}, 32'(inc_pulse), 32'd0);
        chk({tag, "_editing"}, 32'(editing), 32'd0);
        chk({tag, "_auto"}, 32'(auto_on), 32'd1);
    endtask

    initial begin
        // 1: reset, auto rotate
        cyc(3);
        chk_reset_vals("rst");
        #2 rst_n = 1'b1;
        cyc(2);
        for (int i = 1; i <= 3; i++) begin
            pulse_tick();
            chk("auto_tick_sw", 32'(sw), (i == 3) ? 32'd1 : 32'd0);
            cyc(2);
        end
        for (int i = 1; i <= 2; i++) begin
            pulse_tick();
            chk("date_tick_sw", 32'(sw), (i == 2) ? 32'd0 : 32'd1);
            cyc(2);
        end
        chk("auto_blank", 32'(blank), 32'd0);

        // 2: bounces of 1..3 cycles are rejected
        for (int w = 1; w <= 3; w++) begin
            btn_mode = 1'b1;
            cyc(w);
            btn_mode = 1'b0;
            cyc(6);
        end
        chk("bounce_auto", 32'(auto_on), 32'd1);
        btn_mode = 1'b1;
        cyc(7);
        chk("mode_lat7_auto", 32'(auto_on), 32'd1);
        cyc(1);
        chk("mode_lat8_auto", 32'(auto_on), 32'd0);
        rel(1);
        chk("man_sw0", 32'(sw), 32'd0);
        push(1);
        chk("man_toggle_sw", 32'(sw), 32'd1);
        rel(1);
        push(2);
        chk("up_to_auto", 32'(auto_on), 32'd1);
        rel(2);

        // 3: edit in date view, blink and field cycling
        push(0);
        chk("edit_day", 32'(edit_field), 32'd4);
        chk("edit_on", 32'(editing), 32'd1);
        chk("blink_off0", 32'(blank), 32'd0);
        rel(0);
        chk("blink_day", 32'(blank), 32'hC0);
        cyc(8);
        chk("blink_off1", 32'(blank), 32'd0);
        push(1);
        chk("edit_month", 32'(edit_field), 32'd5);
        rel(1);
        chk("blink_month", 32'(blank), 32'h30);
        push(1);
        chk("edit_year", 32'(edit_field), 32'd6);
        rel(1);
        chk("blink_year", 32'(blank), 32'h0F);
        push(1);
        chk("edit_wrap_day", 32'(edit_field), 32'd4);
        rel(1);

        // 4: time-view edit, up increment, exit via set
        push(0);
        chk("exit_field", 32'(edit_field), 32'd0);
        rel(0);
        push(1);
        chk("man_time", 32'(sw), 32'd0);
        rel(1);
        push(0);
        chk("edit_hour", 32'(edit_field), 32'd3);
        rel(0);
        btn_up = 1'b1;
        cyc(7);
        chk("inc_before", 32'(inc_pulse), 32'd0);
        cyc(1);
        chk("inc_pulse", 32'(inc_pulse), 32'd1);
        chk("inc_field", 32'(edit_field), 32'd3);
        chk("inc_blank", 32'(blank), 32'd0);
        cyc(1);
        chk("inc_once", 32'(inc_pulse), 32'd0);
        cyc(6);
        chk("inc_blink_rst", 32'(blank), 32'd0);
        cyc(1);
        chk("inc_blink_on", 32'(blank), 32'hC0);
        rel(2);
        push(0);
        chk("set_exit_edit", 32'(editing), 32'd0);
        chk("set_exit_blank", 32'(blank), 32'd0);
        rel(0);

        // 5: idle timeout
        push(0);
        rel(0);
        for (int i = 1; i <= 5; i++) begin
            pulse_tick();
            if (i == 4) chk("timeout_not_yet", 32'(editing), 32'd1);
            if (i == 5) begin
                chk("timeout_edit", 32'(editing), 32'd0);
                chk("timeout_man", 32'(auto_on), 32'd0);
                chk("timeout_sw", 32'(sw), 32'd0);
            end
            cyc(1);
        end

        // 6: simultaneous set+mode, then reset mid-edit with up held
        btn_set = 1'b1;
        btn_mode = 1'b1;
        cyc(8);
        chk("prio_field", 32'(edit_field), 32'd3);
        cyc(1);
        chk("prio_field_hold", 32'(edit_field), 32'd3);
        btn_set = 1'b0;
        btn_mode = 1'b0;
        cyc(8);
        btn_up = 1'b1;
        cyc(3);
        #2 rst_n = 1'b0;
        cyc(1);
        chk_reset_vals("midrst");
        cyc(2);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cyc(1);
            chk("held_up_inc", 32'(inc_pulse), 32'd0);
            chk("held_up_auto", 32'(auto_on), 32'd1);
        end
        btn_up = 1'b0;
        cyc(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
